// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and flag bit positions for the multi-cycle execute ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_MUL    = 4'hC;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one-bit-per-cycle shifter and (with ALU_MUL_EN) a radix-2 Booth multiplier.
// Owns the working registers and the shared step counter.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_shift,
  input  logic                       load_mul,
  input  logic                       step_shift,
  input  logic                       step_mul,
  input  logic [3:0]                 op,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [$clog2(WIDTH)-1:0]   amt,
  output logic [WIDTH-1:0]           shift_c,
  output logic                       last_c,
  output logic [WIDTH-1:0]           mul_lo_c,
  output logic                       mul_ovf_c
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] src;
  logic [3:0]       sop;

  // The load cycle already performs the first shift, so the source is the operand then.
  always_comb begin
    src     = load_shift ? a : work;
    sop     = load_shift ? op : op_q;
    shift_c = src;
    case (sop)
      OP_SLL:  shift_c = {src[WIDTH-2:0], 1'b0};
      OP_SRA:  shift_c = {src[WIDTH-1], src[WIDTH-1:1]};
      OP_ROR:  shift_c = {src[0], src[WIDTH-1:1]};
      default: shift_c = src;
    endcase
  end

  assign last_c = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
      op_q <= OP_ADD;
    end else if (load_shift) begin
      work <= shift_c;
      cnt  <= CW'(amt) - CW'(1);
      op_q <= op;
    end else if (step_shift) begin
      work <= shift_c;
      cnt  <= cnt - CW'(1);
    end
`ifdef ALU_MUL_EN
    else if (load_mul) begin
      cnt <= CW'(WIDTH);
    end else if (step_mul) begin
      cnt <= cnt - CW'(1);
    end
`endif
  end

`ifdef ALU_MUL_EN
  // Booth radix-2: acc carries one guard bit so subtracting the most negative multiplicand cannot wrap.
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mplier_nx;
  logic [WIDTH-1:0] mcand;
  logic             q_m1;

  always_comb begin
    acc_sum = acc;
    case ({mplier[0], q_m1})
      2'b01:   acc_sum = acc + {mcand[WIDTH-1], mcand};
      2'b10:   acc_sum = acc - {mcand[WIDTH-1], mcand};
      default: acc_sum = acc;
    endcase
    acc_nx    = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    mplier_nx = {acc_sum[0], mplier[WIDTH-1:1]};
  end

  assign mul_lo_c  = mplier_nx;
  assign mul_ovf_c = (acc_nx[WIDTH-1:0] != {WIDTH{mplier_nx[WIDTH-1]}});

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      q_m1   <= 1'b0;
    end else if (load_mul) begin
      acc    <= '0;
      mplier <= b;
      mcand  <= a;
      q_m1   <= 1'b0;
    end else if (step_mul) begin
      acc    <= acc_nx;
      mplier <= mplier_nx;
      q_m1   <= mplier[0];
    end
  end
`else
  logic unused_mul;
  assign unused_mul = ^{b, load_mul, step_mul};
  assign mul_lo_c   = '0;
  assign mul_ovf_c  = 1'b0;
`endif

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU with valid/ready on both sides and a registered ZVN flag set.
// Optional signed multiply on opcode C is enabled by defining ALU_MUL_EN.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       flags
);

  localparam int unsigned SW    = $clog2(WIDTH);
  localparam int unsigned NLANE = WIDTH / LANE;
  localparam int unsigned NBYTE = WIDTH / 8;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic             xfer;
  logic             shift_op;
  logic [SW-1:0]    amt;
  logic             load_shift;
  logic             load_mul;
  logic [WIDTH-1:0] shift_c;
  logic             last_c;
  logic [WIDTH-1:0] mul_lo_c;
  logic             mul_ovf_c;

  assign xfer       = in_valid && in_ready;
  assign shift_op   = is_shift_op(opcode);
  assign amt        = in_b[SW-1:0];
  assign load_shift = xfer && shift_op && (amt != '0);
`ifdef ALU_MUL_EN
  assign load_mul   = xfer && (opcode == OP_MUL);
`else
  assign load_mul   = 1'b0;
  logic unused_mul;
  assign unused_mul = ^{mul_lo_c, mul_ovf_c};
`endif

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .rst        (rst),
    .load_shift (load_shift),
    .load_mul   (load_mul),
    .step_shift (state == S_SHIFT),
    .step_mul   (state == S_MUL),
    .op         (opcode),
    .a          (in_a),
    .b          (in_b),
    .amt        (amt),
    .shift_c    (shift_c),
    .last_c     (last_c),
    .mul_lo_c   (mul_lo_c),
    .mul_ovf_c  (mul_ovf_c)
  );

  // Lane-wise saturating add
  logic [WIDTH-1:0] padd_c;
  logic [LANE-1:0]  lane_a, lane_b, lane_s;
  always_comb begin
    padd_c = '0;
    lane_a = '0;
    lane_b = '0;
    lane_s = '0;
    for (int l = 0; l < int'(NLANE); l++) begin
      lane_a = in_a[l*LANE +: LANE];
      lane_b = in_b[l*LANE +: LANE];
      lane_s = lane_a + lane_b;
      if ((lane_a[LANE-1] == lane_b[LANE-1]) && (lane_s[LANE-1] != lane_a[LANE-1]))
        lane_s = lane_a[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
      padd_c[l*LANE +: LANE] = lane_s;
    end
  end

  // Signed byte reduction over both operands
  logic [WIDTH-1:0] red_c;
  always_comb begin
    red_c = '0;
    for (int i = 0; i < int'(NBYTE); i++)
      red_c = red_c + WIDTH'($signed(in_a[i*8 +: 8])) + WIDTH'($signed(in_b[i*8 +: 8]));
  end

  logic [WIDTH-1:0] sum, dif, res_c;
  logic             add_ovf, sub_ovf, res_v, upd_z, upd_vn;
  logic [2:0]       flags_nx;

  always_comb begin
    sum     = in_a + in_b;
    dif     = in_a - in_b;
    add_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    sub_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (dif[WIDTH-1] != in_a[WIDTH-1]);
    res_c   = '0;
    res_v   = 1'b0;
    upd_z   = 1'b0;
    upd_vn  = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_c  = add_ovf ? (in_a[WIDTH-1] ? SMIN : SMAX) : sum;
        res_v  = add_ovf;
        upd_z  = 1'b1;
        upd_vn = 1'b1;
      end
      OP_SUB: begin
        res_c  = sub_ovf ? (in_a[WIDTH-1] ? SMIN : SMAX) : dif;
        res_v  = sub_ovf;
        upd_z  = 1'b1;
        upd_vn = 1'b1;
      end
      OP_XOR: begin
        res_c = in_a ^ in_b;
        upd_z = 1'b1;
      end
      OP_RED:                 res_c = red_c;
      OP_SLL, OP_SRA, OP_ROR: begin
        res_c = (amt == '0) ? in_a : shift_c;
        upd_z = 1'b1;
      end
      OP_PADDSB:              res_c = padd_c;
      OP_LW, OP_SW:           res_c = (in_a & ~WIDTH'(1)) + (in_b << 1);
      OP_LLB:                 res_c = (in_b & ~WIDTH'(8'hFF)) | in_a;
      OP_LHB:                 res_c = (in_b & WIDTH'(8'hFF)) | (in_a << 8);
      default:                res_c = '0;
    endcase
    flags_nx = flags;
    if (upd_z) flags_nx[FLAG_Z] = (res_c == '0);
    if (upd_vn) begin
      flags_nx[FLAG_V] = res_v;
      flags_nx[FLAG_N] = res_c[WIDTH-1];
    end
  end

  // Control FSM; out_data and flags only change on HOLD entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      flags     <= '0;
    end else begin
      case (state)
        S_IDLE: if (xfer) begin
          in_ready <= 1'b0;
          if (shift_op && (amt > SW'(1))) begin
            state <= S_SHIFT;
          end
`ifdef ALU_MUL_EN
          else if (opcode == OP_MUL) begin
            state <= S_MUL;
          end
`endif
          else begin
            state     <= S_HOLD;
            out_valid <= 1'b1;
            out_data  <= res_c;
            flags     <= flags_nx;
          end
        end
        S_SHIFT: if (last_c) begin
          state         <= S_HOLD;
          out_valid     <= 1'b1;
          out_data      <= shift_c;
          flags[FLAG_Z] <= (shift_c == '0);
        end
`ifdef ALU_MUL_EN
        S_MUL: if (last_c) begin
          state         <= S_HOLD;
          out_valid     <= 1'b1;
          out_data      <= mul_lo_c;
          flags[FLAG_Z] <= (mul_lo_c == '0);
          flags[FLAG_V] <= mul_ovf_c;
          flags[FLAG_N] <= mul_lo_c[WIDTH-1];
        end
`endif
        S_HOLD: if (out_ready) begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=16, LANE=4; honours ALU_MUL_EN when defined.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(16), .LANE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flags     (flags)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  flg;
    logic [7:0]  lat;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] mflags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference model returns {flags, data}; flags are {Z,V,N}
  function automatic logic [18:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [2:0] fin);
    int          sa, sbv, r, amt, ls;
    longint      p;
    logic [15:0] d;
    logic [2:0]  f;
    logic [3:0]  la, lb;
    sa  = $signed(a);
    sbv = $signed(b);
    amt = int'(b[3:0]);
    d   = 16'h0;
    f   = fin;
    p   = 0;
    case (op)
      4'h0, 4'h1: begin
        r = (op == 4'h0) ? sa + sbv : sa - sbv;
        f[1] = (r > 32767) || (r < -32768);
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        d = r[15:0];
        f[2] = (d == 16'h0);
        f[0] = d[15];
      end
      4'h2: begin d = a ^ b; f[2] = (d == 16'h0); end
      4'h3: begin
        r = 0;
        for (int i = 0; i < 2; i++) begin
          r += $signed(a[i*8 +: 8]);
          r += $signed(b[i*8 +: 8]);
        end
        d = r[15:0];
      end
      4'h4: begin d = a << amt; f[2] = (d == 16'h0); end
      4'h5: begin d = $signed(a) >>> amt; f[2] = (d == 16'h0); end
      4'h6: begin d = (a >> amt) | (a << (16 - amt)); f[2] = (d == 16'h0); end
      4'h7: begin
        for (int l = 0; l < 4; l++) begin
          la = a[l*4 +: 4];
          lb = b[l*4 +: 4];
          ls = $signed(la) + $signed(lb);
          if (ls > 7) ls = 7;
          if (ls < -8) ls = -8;
          d[l*4 +: 4] = ls[3:0];
        end
      end
      4'h8, 4'h9: d = (a & 16'hFFFE) + (b << 1);
      4'hA: d = (b & 16'hFF00) | a;
      4'hB: d = (b & 16'h00FF) | (a << 8);
      4'hC: begin
`ifdef ALU_MUL_EN
        p = longint'(sa) * longint'(sbv);
        d = p[15:0];
        f[1] = (p > 32767) || (p < -32768);
        f[2] = (d == 16'h0);
        f[0] = d[15];
`else
        d = 16'h0;
`endif
      end
      default: d = 16'h0;
    endcase
    return {f, d};
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [3:0] amt);
    if (op == 4'h4 || op == 4'h5 || op == 4'h6) return (amt == 4'h0) ? 1 : int'(amt);
`ifdef ALU_MUL_EN
    if (op == 4'hC) return 17;
`endif
    return 1;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int hold);
    exp_t        e;
    exp_t        got_e;
    logic [18:0] m;
    int          lat;
    int          w;
    logic        busy_ready;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, " accept"}, 32'(in_ready), 32'd1);
    m      = model(op, a, b, mflags);
    mflags = m[18:16];
    e.data = m[15:0];
    e.flg  = m[18:16];
    e.lat  = 8'(lat_of(op, b[3:0]));
    sb.push_back(e);
    opcode   = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    lat        = 1;
    busy_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      busy_ready |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    busy_ready |= in_ready;
    got_e = sb.pop_front();
    check({tag, " latency"}, 32'(lat), 32'(got_e.lat));
    check({tag, " in_ready_busy"}, 32'(busy_ready), 32'd0);
    check({tag, " data"}, 32'(out_data), 32'(got_e.data));
    check({tag, " flags"}, 32'(flags), 32'(got_e.flg));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, 32'({out_valid, in_ready, flags, out_data}),
            32'({1'b1, 1'b0, got_e.flg, got_e.data}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " drain"}, 32'({out_valid, in_ready}), 32'd1);
  endtask

  // Abort a long operation with rst at cycle 8 and look at cycle 9
  task automatic reset_mid();
`ifdef ALU_MUL_EN
    opcode = 4'hC; in_a = 16'h0003; in_b = 16'hFFFE;
`else
    opcode = 4'h5; in_a = 16'h8000; in_b = 16'h000F;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("rst_mid busy", 32'({out_valid, in_ready}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid out_valid", 32'(out_valid), 32'd0);
    check("rst_mid in_ready", 32'(in_ready), 32'd1);
    check("rst_mid flags", 32'(flags), 32'd0);
    check("rst_mid out_data", 32'(out_data), 32'd0);
    rst    = 1'b0;
    mflags = 3'b000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0]  rop;
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 4'h0; in_a = 16'h0; in_b = 16'h0; mflags = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset flags", 32'(flags), 32'd0);

    run_op("add_sat",  4'h0, 16'h7FFF, 16'h0001, 0);
    run_op("sra4",     4'h5, 16'h8000, 16'h0004, 0);
    run_op("paddsb",   4'h7, 16'h7777, 16'h1111, 0);
    run_op("lw",       4'h8, 16'h1001, 16'h0004, 0);
    run_op("mul",      4'hC, 16'h0003, 16'hFFFE, 0);
    run_op("xor_hold", 4'h2, 16'h00FF, 16'h00FF, 3);
    run_op("sub_sat",  4'h1, 16'h8000, 16'h0001, 1);
    run_op("sll0",     4'h4, 16'h1234, 16'h0000, 0);
    run_op("sll1",     4'h4, 16'h8001, 16'h0001, 0);
    run_op("ror15",    4'h6, 16'h0001, 16'h000F, 0);
    run_op("sra15",    4'h5, 16'h8001, 16'h000F, 2);
    run_op("red",      4'h3, 16'h80FF, 16'h7F01, 0);
    run_op("llb",      4'hA, 16'h0034, 16'hAB12, 0);
    run_op("lhb",      4'hB, 16'h00CD, 16'hAB12, 0);
    run_op("sw",       4'h9, 16'hFFFF, 16'h8000, 0);
    run_op("op_e",     4'hE, 16'h1234, 16'h5678, 0);
    run_op("pre_rst",  4'h0, 16'h7FFF, 16'h0001, 0);
    reset_mid();
    run_op("post_rst", 4'h1, 16'h0005, 16'h0005, 0);

    for (int k = 0; k < 40; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
